pipe_csa_adder: RTL and testbench

Pipelined WIDTH-bit two-operand adder built as a chain of 2-bit full-adder slices (the `FA2` slice: 2-bit a/b, carry-in, 2-bit sum, 2-bit carry vector). One slice per pipeline stage, with the inter-slice carry registered between stages. Operand skew and result deskew registers keep each transaction aligned. A valid/ready handshake on both sides provides back-pressure. It sits between the operand-issue logic and the writeback register in the pipelined datapath, replacing the single-cycle ripple adder.

---
 rtl/pipe_csa_adder.sv | 115 +++++++++++
 tb/tb_pipe_csa_adder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_csa_adder.sv
// pipe_csa_adder: WIDTH-bit adder pipelined as a chain of 2-bit full-adder slices, one slice per stage.
// Defining PIPE_CSA_OVF_EN adds a registered signed-overflow output; otherwise ovf is tied low.
module pipe_csa_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int N = WIDTH / 2;

    logic adv;

    // The whole pipe moves as one unit; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : stg
            logic [WIDTH-1:2*gi] a_src;
            logic [WIDTH-1:2*gi] b_src;
            logic                cin;
            logic                vin;
            logic [2*gi+1:0]     sum_next;
            logic [1:0]          fa_s;
            logic [1:0]          fa_c;
            logic                valid_reg;
            logic                carry_reg;
            logic [2*gi+1:0]     sum_reg;

            if (gi == 0) begin : g_head
                assign a_src    = a;
                assign b_src    = b;
                assign cin      = c_in;
                assign vin      = in_valid;
                assign sum_next = fa_s;
            end else begin : g_body
                assign a_src    = stg[gi-1].g_skew.a_reg;
                assign b_src    = stg[gi-1].g_skew.b_reg;
                assign cin      = stg[gi-1].carry_reg;
                assign vin      = stg[gi-1].valid_reg;
                assign sum_next = {fa_s, stg[gi-1].sum_reg};
            end

            // FA2 slice: fa_c[0] is the carry into the upper bit, fa_c[1] the slice carry-out.
            assign fa_s[0] = a_src[2*gi] ^ b_src[2*gi] ^ cin;
            assign fa_c[0] = (a_src[2*gi] & b_src[2*gi])
                           | (cin & (a_src[2*gi] ^ b_src[2*gi]));
            assign fa_s[1] = a_src[2*gi+1] ^ b_src[2*gi+1] ^ fa_c[0];
            assign fa_c[1] = (a_src[2*gi+1] & b_src[2*gi+1])
                           | (fa_c[0] & (a_src[2*gi+1] ^ b_src[2*gi+1]));

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    carry_reg <= 1'b0;
                    sum_reg   <= '0;
                end else if (adv) begin
                    valid_reg <= vin;
                    carry_reg <= fa_c[1];
                    sum_reg   <= sum_next;
                end
            end

            // Operand skew: only bits of slices not yet consumed travel onward.
            if (gi < N - 1) begin : g_skew
                logic [WIDTH-1:2*gi+2] a_reg;
                logic [WIDTH-1:2*gi+2] b_reg;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_reg <= '0;
                        b_reg <= '0;
                    end else if (adv) begin
                        a_reg <= a_src[WIDTH-1:2*gi+2];
                        b_reg <= b_src[WIDTH-1:2*gi+2];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = stg[N-1].valid_reg;
    assign sum       = stg[N-1].sum_reg;
    assign c_out     = stg[N-1].carry_reg;

`ifdef PIPE_CSA_OVF_EN
    logic ovf_reg;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (adv) begin
            ovf_reg <= stg[N-1].fa_c[1] ^ stg[N-1].fa_c[0];
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_csa_adder.sv
// Self-checking bench for pipe_csa_adder (WIDTH = 8): directed scenarios plus random traffic
// against an arithmetic scoreboard.
`timescale 1ns/1ps
module tb_pipe_csa_adder;

    localparam int WIDTH = 8;
`ifdef PIPE_CSA_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    int n_assert = 0;
    int n_fail   = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_csa_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic, {ovf, c_out, sum}.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic ci);
        int unsigned t;
        int          s;
        logic        o;
        t = int'(x) + int'(y) + int'(ci);
        s = int'($signed(x)) + int'($signed(y)) + int'(ci);
        o = OVF_EN && ((s > 127) || (s < -128));
        return {o, t[8], t[7:0]};
    endfunction

    // One clock cycle: drive at negedge, check/score just after, edge follows.
    task automatic cycle(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                         input logic ic, input logic ordy, input logic r);
        logic [9:0] e;
        @(negedge clk);
        rst = r; in_valid = iv; a = ia; b = ib; c_in = ic; out_ready = ordy;
        #1;
        if (r) begin
            exp_q.delete();
        end else begin
            check("in_ready", in_ready, !out_valid || out_ready);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", sum, e[7:0]);
                    check("c_out", c_out, e[8]);
                    check("ovf", ovf, e[9]);
                    $display("result a/b/c -> sum=0x%02h c_out=%0d ovf=%0d", sum, c_out, ovf);
                end
            end
            if (iv && in_ready) exp_q.push_back(model(ia, ib, ic));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic ripple(input logic [7:0] x, input logic [7:0] y, input logic ci);
        cycle(1'b1, x, y, ci, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
            check("latency_early", out_valid, 0);
        end
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        check("latency_edge4", out_valid, 1);
    endtask

    initial begin
        logic [7:0] held_sum;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;

        // Reset then idle
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 8'h55, 8'h55, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_c_out", c_out, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
            check("idle_out_valid", out_valid, 0);
        end

        // Full carry ripple, with and without carry-in
        ripple(8'hFF, 8'h01, 1'b0);
        ripple(8'hFF, 8'h01, 1'b1);

        // Back-to-back
        cycle(1'b1, 8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'hF0, 8'h0F, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 8'h80, 8'h80, 1'b0, 1'b1, 1'b0);
        idle(6);
        check("b2b_drained", exp_q.size(), 0);

        // Back-pressure: stall 3 cycles with the first result valid
        cycle(1'b1, 8'h21, 8'h43, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'hA5, 8'h5A, 1'b1, 1'b1, 1'b0);
        idle(2);
        held_sum = 8'h00;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h77, 8'h11, 1'b0, 1'b0, 1'b0);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            if (i == 0) held_sum = sum;
            else check("stall_sum_stable", sum, held_sum);
        end
        check("stall_sum_value", held_sum, 8'h64);
        idle(6);
        check("bp_drained", exp_q.size(), 0);

        // Reset mid-flight
        cycle(1'b1, 8'h01, 8'h02, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h03, 8'h04, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h05, 8'h06, 1'b0, 1'b1, 1'b0);
        idle(1);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
            check("post_rst_out_valid", out_valid, 0);
        end

        // Overflow cases
        ripple(8'h7F, 8'h01, 1'b0);
        check("ovf_7f", ovf, OVF_EN);
        ripple(8'hFF, 8'h01, 1'b0);
        check("ovf_ff", ovf, 0);

        // Random traffic with random back-pressure
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
                  1'($urandom), ($urandom_range(0, 9) < 7), 1'b0);
        end
        idle(8);
        check("rand_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
